instr_queue: RTL
================

Name: instr_queue

Overview:
- In-order FIFO of decoded instruction packs between the decoder and the dispatcher.
- Absorbs dispatcher stalls so the fetch/decode front end only stalls when the queue is full.
- First-word-fall-through: the head entry is always presented to the dispatcher.
- Flushed on branch mispredict or exception recovery.

Parameters:
- IQ_DEPTH, 8, number of entries; power of two, minimum 2.
- IQ_AFULL_TH, 2, almost_full asserts when free entries are at or below this value.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high.
- flush  input  1  squash all entries (mispredict/recovery).
- in_valid  input  1  decoder presents a valid pack.
- in_pack  input  $bits(DECODED_PACK)  decoded instruction from the decoder.
- in_ready  output  1  queue can accept this cycle.
- out_valid  output  1  head entry valid.
- out_pack  output  $bits(DECODED_PACK)  head decoded instruction to the dispatcher.
- deq_stall  input  1  dispatcher stall; head is not consumed while high.
- count  output  $clog2(IQ_DEPTH+1)  number of occupied entries.
- full  output  1  count == IQ_DEPTH.
- almost_full  output  1  (IQ_DEPTH - count) <= IQ_AFULL_TH.

Behaviour:
- Storage: IQ_DEPTH-entry array; head/tail pointers of $clog2(IQ_DEPTH) bits, wrapping modulo IQ_DEPTH; separate count register.
- enq = in_valid & in_ready & ~flush.
- deq = out_valid & ~deq_stall & ~flush.
- in_ready = ~full. A full queue does not accept, even if it dequeues in the same cycle; no pass-through when full.
- out_valid = (count != 0). out_pack = mem[head], combinational from storage.
- Latency: a pack enqueued at edge N is visible on out_valid/out_pack after edge N (cycle N+1). Throughput is 1 pack per cycle.
- Simultaneous enq and deq (not full, not empty): tail++ and head++; count unchanged.
- Enqueue when empty: out_valid rises in the next cycle only. Same-cycle bypass exists only under the optional feature.
- Dequeue when empty: impossible; out_valid is 0.
- Pointer wrap: tail = IQ_DEPTH-1 followed by an enq gives tail = 0. Same for head.
- flush: at the next edge head = tail = 0 and count = 0. flush has priority over enq/deq in the same cycle; in_valid is ignored during the flush cycle.
- reset: identical to flush; storage contents are don't-care.
- Reset values: out_valid = 0, in_ready = 1, count = 0, full = 0, almost_full = (IQ_DEPTH <= IQ_AFULL_TH), out_pack = don't-care (zero when empty is allowed).
- Holding: while deq_stall = 1, out_pack must stay stable cycle to cycle until consumed.
- State: no FSM beyond the pointers and count; the empty and full conditions are derived from count.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- With the macro defined: when count == 0, in_valid = 1, ~deq_stall and ~flush, then out_valid = 1 and out_pack = in_pack in the same cycle. The pack is consumed directly, and no write, pointer move or count change occurs.
  - If deq_stall = 1 in that case, the pack is enqueued normally.
- Without the macro: no combinational path from in_* to out_*; minimum latency is 1 cycle.

Decomposition:
- Shared header (dispatcher.svh): IQ_DEPTH default and IQ_PTR_LEN (`define`). DECODED_PACK stays in decoder.svh.
- One natural sub-module: iq_ring_ptr, a wrapping pointer with inc/clear inputs, instantiated twice for head and tail.

Test Plan:
- Reset, then enqueue A, B, C on consecutive cycles with deq_stall = 0 → out_pack shows A at cycle 1, B at cycle 2, C at cycle 3; count never exceeds 1.
- deq_stall = 1 while enqueuing 8 packs (IQ_DEPTH = 8) →
  - count goes 1..8;
  - almost_full at count = 6;
  - full at 8 and in_ready = 0;
  - a 9th in_valid is not accepted;
  - out_pack stays equal to pack 0 throughout.
- Full queue, release deq_stall for 8 cycles → packs 0..7 come out in order; head wraps 7→0; full drops after the first dequeue.
- Count = 4 with simultaneous enq and deq for 10 cycles → count stays 4; order is preserved across tail wrap.
- Count = 5 with flush and in_valid in the same cycle → next cycle count = 0, out_valid = 0, the incoming pack is dropped. A subsequent enqueue of X appears at the head.
- IQ_BYPASS_EN: empty queue, in_valid with X, deq_stall = 0 → out_valid = 1 and out_pack = X in the same cycle; count remains 0. Repeat with deq_stall = 1 → count = 1 next cycle.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// Shared types and defaults for the decoder-to-dispatcher instruction queue.
package instr_queue_pkg;

    localparam int unsigned IQ_DEPTH_DEF    = 8;
    localparam int unsigned IQ_AFULL_TH_DEF = 2;

    typedef struct packed {
        logic [7:0] uop;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [8:0] imm;
    } decoded_pack_t;

    localparam int unsigned PACK_W = $bits(decoded_pack_t);

endpackage

// File: rtl/instr_queue_if.sv
// Decoder/dispatcher handshake bundle for instr_queue; slave = queue side.
interface instr_queue_if
    import instr_queue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = IQ_DEPTH_DEF
) ();
    logic                             in_valid;
    decoded_pack_t                    in_pack;
    logic                             in_ready;
    logic                             out_valid;
    decoded_pack_t                    out_pack;
    logic                             deq_stall;
    logic [$clog2(IQ_DEPTH+1)-1:0]    count;
    logic                             full;
    logic                             almost_full;

    modport slave (
        input  in_valid, in_pack, deq_stall,
        output in_ready, out_valid, out_pack, count, full, almost_full
    );

    modport master (
        output in_valid, in_pack, deq_stall,
        input  in_ready, out_valid, out_pack, count, full, almost_full
    );
endinterface

// File: rtl/instr_queue_ring_ptr.sv
// Wrapping ring pointer with synchronous clear; width sets the wrap modulus.
module iq_ring_ptr #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);
    logic [W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (i_clear)
            r_ptr <= '0;
        else if (i_inc)
            r_ptr <= r_ptr + W'(1);
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/instr_queue.sv
// First-word-fall-through instruction queue between decoder and dispatcher.
// Optional same-cycle empty-queue bypass enabled by defining IQ_BYPASS_EN.
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int unsigned IQ_DEPTH    = IQ_DEPTH_DEF,
    parameter int unsigned IQ_AFULL_TH = IQ_AFULL_TH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    instr_queue_if.slave  q
);
    localparam int unsigned PW = $clog2(IQ_DEPTH);
    localparam int unsigned CW = $clog2(IQ_DEPTH + 1);

    decoded_pack_t  r_mem [IQ_DEPTH];
    logic [CW-1:0]  r_count;
    logic [PW-1:0]  w_head;
    logic [PW-1:0]  w_tail;
    logic [CW-1:0]  w_free;
    logic           w_clear;
    logic           w_empty;
    logic           w_full;
    logic           w_bypass;
    logic           w_enq;
    logic           w_deq;

    assign w_clear = reset | flush;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(IQ_DEPTH));
    assign w_free  = CW'(IQ_DEPTH) - r_count;

`ifdef IQ_BYPASS_EN
    // Pack goes straight to the dispatcher; storage and pointers are untouched.
    assign w_bypass = w_empty & q.in_valid & ~q.deq_stall & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_enq = q.in_valid & ~w_full & ~flush & ~w_bypass;
    assign w_deq = ~w_empty & ~q.deq_stall & ~flush;

    iq_ring_ptr #(.W(PW)) u_head (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_deq),
        .o_ptr   (w_head)
    );

    iq_ring_ptr #(.W(PW)) u_tail (
        .clk     (clk),
        .i_clear (w_clear),
        .i_inc   (w_enq),
        .o_ptr   (w_tail)
    );

    always_ff @(posedge clk) begin
        if (w_enq)
            r_mem[w_tail] <= q.in_pack;
    end

    always_ff @(posedge clk) begin
        if (w_clear)
            r_count <= '0;
        else if (w_enq && !w_deq)
            r_count <= r_count + CW'(1);
        else if (!w_enq && w_deq)
            r_count <= r_count - CW'(1);
    end

    always_comb begin
        q.out_valid = ~w_empty | w_bypass;
        q.out_pack  = '0;
        if (w_bypass)
            q.out_pack = q.in_pack;
        else if (!w_empty)
            q.out_pack = r_mem[w_head];
    end

    assign q.in_ready    = ~w_full;
    assign q.count       = r_count;
    assign q.full        = w_full;
    assign q.almost_full = (w_free <= CW'(IQ_AFULL_TH));
endmodule
